// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and the supported data width.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: little-endian load extract with sign/zero
// extension, and byte/halfword merge of store data into a read word.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_byte_off,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_ld_data,
  output logic [DATA_W-1:0] o_st_word
);

  logic [DATA_W-1:0] w_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_shift = i_word >> {i_byte_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_ld_data = i_word;
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_word;
    endcase
  end

  // Untouched lanes keep the value just read from memory.
  always_comb begin
    o_st_word = i_word;
    case (i_funct3)
      F3_B: o_st_word[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_byte_off[1]) o_st_word[31:16] = i_wdata[15:0];
        else               o_st_word[15:0]  = i_wdata[15:0];
      end
      default: o_st_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store sequencer for a single-port data memory: one request at a time,
// read-modify-write for sub-word stores, one response per accepted request.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  lsu_state_t            r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_wbuf;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_accept;
  logic                  w_f3_ok;
  logic                  w_misal;
  logic                  w_oor;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_st_word;

  assign w_word_addr = req_addr[ADDR_WIDTH+1:2];
  assign w_accept    = req_valid && req_ready;

  assign w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                   (!req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
  assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_oor   = |(req_addr >> (ADDR_WIDTH + 2));
  assign w_err   = !w_f3_ok || w_misal || w_oor;

  lsu_lane_unit u_lane (
    .i_funct3   (r_funct3),
    .i_byte_off (r_off),
    .i_word     (mem_data_out),
    .i_wdata    (r_wdata),
    .o_ld_data  (w_ld_data),
    .o_st_word  (w_st_word)
  );

  // Response fields only change on the edge entering RESP, so they hold
  // steady between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_waddr  <= w_word_addr;
            r_wdata  <= req_wdata;
            if (w_err) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= RESP;
            end else if (!req_we) begin
              r_state <= LD;
            end else if (req_funct3 == F3_W) begin
              r_wbuf  <= req_wdata;
              r_state <= WR;
            end else begin
              r_state <= RMW_RD;
            end
          end
        end
        LD: begin
          r_rdata <= w_ld_data;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RMW_RD: begin
          r_wbuf  <= w_st_word;
          r_state <= WR;
        end
        WR: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE) && rst_n;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_err     = r_err;
  assign rsp_rdata   = r_rdata;
  assign mem_re      = (r_state == LD) || (r_state == RMW_RD);
  assign mem_we      = (r_state == WR);
  assign mem_data_in = r_wbuf;
  // In IDLE the request address goes straight out so memory latches it on the accept edge.
  assign mem_addr    = (r_state == IDLE) ? w_word_addr : r_waddr;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized self-checking bench for data_mem_lsu with a byte-level reference model.
module tb_data_mem_lsu;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_data_out;

  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_re(mem_re), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: write on edge, read data one cycle after address, gated by re.
  logic [31:0]   mem [256];
  logic [AW-1:0] r_maddr;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data_in;
    r_maddr <= mem_addr;
  end
  assign mem_data_out = mem_re ? mem[r_maddr] : 32'd0;

  typedef struct { int cyc; logic err; logic [31:0] rdata; } exp_t;
  exp_t        q[$];
  exp_t        ce;
  int          exp_we_cyc = -1;
  logic [31:0] exp_wdata = 32'd0;
  int          exp_re_cyc = -1;
  int          rsp_seen = 0;
  logic [31:0] ref_mem [256];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: access size from funct3, bytes selected by shifting/masking the word.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                output int lat, output logic wr, output logic [31:0] nw,
                                output logic rdm);
    int size; int sh; longint mask; longint val; longint old; logic [7:0] w;
    w    = addr[9:2];
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sh   = 8 * int'(addr[1:0]);
    err  = !((f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5))) ||
           ((addr % size) != 0) || (addr >= 32'd1024);
    rd = 32'd0; wr = 1'b0; nw = 32'd0; rdm = 1'b0; lat = 1;
    if (!err) begin
      mask = (64'd1 << (8 * size)) - 1;
      if (!we) begin
        val = (longint'(ref_mem[w]) >> sh) & mask;
        if (!f3[2] && size < 4 && ((val >> (8 * size - 1)) & 1) != 0) val = val | ~mask;
        rd = val[31:0]; lat = 2; rdm = 1'b1;
      end else begin
        old = longint'(ref_mem[w]);
        ref_mem[w] = 32'((old & ~(mask << sh)) | ((longint'(wd) & mask) << sh));
        nw = ref_mem[w]; wr = 1'b1;
        lat = (size == 4) ? 2 : 3;
        rdm = (size < 4);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 32'(req_ready), 32'(q.size() == 0));
      if (rsp_valid) begin
        rsp_seen++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          ce = q.pop_front();
          check("rsp_cycle", cyc, ce.cyc);
          check("rsp_err", 32'(rsp_err), 32'(ce.err));
          check("rsp_rdata", rsp_rdata, ce.rdata);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got rsp_valid=0 expected 1 (cycle %0d)", cyc);
        void'(q.pop_front());
      end
      if (mem_we || cyc == exp_we_cyc) begin
        check("mem_we", 32'(mem_we), 32'(cyc == exp_we_cyc));
        if (mem_we) check("mem_data_in", mem_data_in, exp_wdata);
      end
      check("mem_re", 32'(mem_re), 32'(cyc == exp_re_cyc));
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gap, input bit pin,
                       input logic perr, input logic [31:0] prd);
    bit ok; int a; int lat; logic err; logic [31:0] rd; logic wr; logic [31:0] nw; logic rdm;
    exp_t e;
    if (gap > 0 || !req_valid) begin
      req_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end else begin
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    end
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    a = cyc;
    model(we, f3, addr, wd, err, rd, lat, wr, nw, rdm);
    e.cyc = a + lat - 1; e.err = err; e.rdata = rd;
    q.push_back(e);
    if (wr) begin exp_we_cyc = a + lat - 2; exp_wdata = nw; end
    exp_re_cyc = rdm ? a : -1;
    if (pin) begin
      check("model_err", 32'(err), 32'(perr));
      check("model_rdata", rd, prd);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50; n++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
    q.delete();
  endtask

  int          seen0;
  logic [31:0] saved;
  logic [31:0] raddr;
  logic [2:0]  rf3;

  initial begin
    for (int i = 0; i < 256; i++) begin
      saved = $urandom;
      mem[i] = saved;
      ref_mem[i] = saved;
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b1, 1'b0, 32'h8899AABB);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1, 1'b1, 1'b0, 32'hFFFFFF88);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1, 1'b1, 1'b0, 32'h00000088);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1, 1'b1, 1'b0, 32'hFFFF8899);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1, 1'b1, 1'b0, 32'h0000AABB);
    issue(1'b1, 3'b000, 32'h11, 32'h123456CC, 1, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b1, 1'b0, 32'h8899CCBB);
    issue(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1, 1'b1, 1'b0, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b1, 1'b0, 32'hBEEFCCBB);

    issue(1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    issue(1'b0, 3'b001, 32'h11, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'h55, 1, 1'b1, 1'b1, 32'h0);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    drain();

    issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0);
    seen0 = rsp_seen;
    issue(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF);
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("held_rsp_count", rsp_seen - seen0, 32'd2);

    // Abort an SB while it sits in its read phase.
    saved = ref_mem[4];
    issue(1'b1, 3'b000, 32'h11, 32'h000000A5, 1, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    req_valid = 1'b0;
    q.delete();
    exp_we_cyc = -1;
    exp_re_cyc = -1;
    ref_mem[4] = saved;
    seen0 = rsp_seen;
    repeat (3) begin
      @(negedge clk);
      check("abort_mem_we", 32'(mem_we), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem_word", mem[4], 32'hBEEFCCBB);
    check("abort_no_rsp", rsp_seen - seen0, 32'd0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b1, 1'b0, 32'hBEEFCCBB);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = 3'b100;
          default: rf3 = 3'b101;
        endcase
      end else begin
        rf3 = 3'($urandom_range(0, 7));
      end
      raddr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) raddr = raddr | (32'd1 << $urandom_range(10, 31));
      issue(1'($urandom_range(0, 1)), rf3, raddr, $urandom, $urandom_range(0, 2),
            1'b0, 1'b0, 32'h0);
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
